// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory geometry, read-return owner encoding and
// the opcode/access-type constants used across the pipeline.
package mips_pkg;

    localparam int MIPS_AW = 10;
    localparam int MIPS_DW = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic       LOAD  = 1'b0;
    localparam logic       STORE = 1'b1;

    // True for the opcodes that need the data port of the shared memory.
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == LW) || (opcode == SW);
    endfunction

endpackage

// File: rtl/mips_starve_ctr.sv
// Saturating aging counter for the fetch requester; flags when the number of
// consecutive denied cycles has reached the configured limit.
module mips_starve_ctr #(
    parameter int CW    = 3,
    parameter int LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    input  logic          hold,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] LIM     = CW'(LIMIT);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (hold) begin
            cnt_reg <= cnt_reg;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt      = cnt_reg;
    assign at_limit = (cnt_reg >= LIM);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the
// data (LW/SW) requester; data has priority, bounded by a fetch aging counter.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW           = MIPS_AW,
    parameter int DW           = MIPS_DW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    owner_e        owner_reg;
    owner_e        owner_next;
    logic [DW-1:0] i_rdata_reg;
    logic [DW-1:0] d_rdata_reg;
    logic [2:0]    starve_cnt;
    logic          starve_hit;
    logic          i_win;
    logic          d_win;

    mips_starve_ctr #(
        .CW    (3),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (i_req && !hold && !i_win),
        .clr      (i_win),
        .hold     (hold),
        .cnt      (starve_cnt),
        .at_limit (starve_hit)
    );

    // Grants are gated by rst_n so nothing reaches the memory during reset.
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (rst_n && !hold) begin
            if (i_req && (!d_req || starve_hit)) begin
                i_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    assign i_gnt     = i_win;
    assign d_gnt     = d_win;
    assign mem_en    = i_win || d_win;
    assign mem_we    = d_win && (d_we == STORE);
    assign mem_wdata = d_win ? d_wdata : '0;

    always_comb begin
        mem_addr = '0;
        if (d_win) begin
            mem_addr = d_addr;
        end else if (i_win) begin
            mem_addr = i_addr;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (i_win) begin
            owner_next = OWN_I;
        end else if (d_win && (d_we == LOAD)) begin
            owner_next = OWN_D;
        end
    end

    // The owner register is the whole return FSM: it names who receives
    // mem_rdata in the cycle following a read grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg   <= OWN_NONE;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            owner_reg <= owner_next;
            if (owner_reg == OWN_I) begin
                i_rdata_reg <= mem_rdata;
            end
            if (owner_reg == OWN_D) begin
                d_rdata_reg <= mem_rdata;
            end
        end
    end

    // Memory read data is valid during the return cycle itself, so it is
    // forwarded then and held from the capture register afterwards.
    assign i_rvalid = (owner_reg == OWN_I);
    assign d_rvalid = (owner_reg == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : i_rdata_reg;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_reg;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural 1024x32 memory.
module tb_mips_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [1024];

    mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic          hold;
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          e_i_gnt;
        logic          e_d_gnt;
        logic          e_mem_we;
        logic [AW-1:0] e_mem_addr;
        logic [DW-1:0] e_mem_wdata;
        logic          e_i_rv;
        logic          e_d_rv;
        logic [DW-1:0] e_i_rdata;
        logic [DW-1:0] e_d_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd);
        hold = h; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[5]    = 32'h2842_0001;
        mem_rdata = '0;

        vecs[0] = '{0,1,10'd5,  0,0,10'd0,  32'h0,         1,0,0,10'd5,  32'h0,         0,0,32'h0,         32'h0};
        vecs[1] = '{0,0,10'd0,  0,0,10'd0,  32'h0,         0,0,0,10'd0,  32'h0,         1,0,32'h2842_0001, 32'h0};
        vecs[2] = '{0,0,10'd0,  1,0,10'd7,  32'h0,         0,1,0,10'd7,  32'h0,         0,0,32'h2842_0001, 32'h0};
        vecs[3] = '{0,0,10'd0,  1,1,10'd200,32'hDEAD_BEEF, 0,1,1,10'd200,32'hDEAD_BEEF, 0,1,32'h2842_0001, 32'h1000_0007};
        vecs[4] = '{0,0,10'd0,  1,0,10'd200,32'h0,         0,1,0,10'd200,32'h0,         0,0,32'h2842_0001, 32'h1000_0007};
        vecs[5] = '{0,0,10'd0,  0,0,10'd0,  32'h0,         0,0,0,10'd0,  32'h0,         0,1,32'h2842_0001, 32'hDEAD_BEEF};
        vecs[6] = '{0,1,10'd200,1,1,10'd200,32'hCAFE_F00D, 0,1,1,10'd200,32'hCAFE_F00D, 0,0,32'h2842_0001, 32'hDEAD_BEEF};
        vecs[7] = '{0,1,10'd200,0,0,10'd0,  32'h0,         1,0,0,10'd200,32'h0,         0,0,32'h2842_0001, 32'hDEAD_BEEF};
        vecs[8] = '{0,0,10'd0,  0,0,10'd0,  32'h0,         0,0,0,10'd0,  32'h0,         1,0,32'hCAFE_F00D, 32'hDEAD_BEEF};
        vecs[9] = '{1,1,10'd3,  1,0,10'd4,  32'h0,         0,0,0,10'd0,  32'h0,         0,0,32'hCAFE_F00D, 32'hDEAD_BEEF};

        // Reset with both requesters active: everything must read zero.
        rst_n = 1'b0;
        drive(0, 1, 10'd5, 1, 1, 10'd9, 32'hFFFF_FFFF);
        next_cycle();
        #1;
        chk("rst_i_gnt",    32'(i_gnt),    32'h0);
        chk("rst_d_gnt",    32'(d_gnt),    32'h0);
        chk("rst_mem_en",   32'(mem_en),   32'h0);
        chk("rst_mem_we",   32'(mem_we),   32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata",    mem_wdata,     32'h0);
        chk("rst_i_rv",     32'(i_rvalid), 32'h0);
        chk("rst_d_rv",     32'(d_rvalid), 32'h0);
        chk("rst_i_rdata",  i_rdata,       32'h0);
        chk("rst_d_rdata",  d_rdata,       32'h0);
        chk("rst_starve",   32'(dut.starve_cnt), 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].hold, vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req,
                  vecs[v].d_we, vecs[v].d_addr, vecs[v].d_wdata);
            chk($sformatf("v%0d_i_gnt", v),    32'(i_gnt),    32'(vecs[v].e_i_gnt));
            chk($sformatf("v%0d_d_gnt", v),    32'(d_gnt),    32'(vecs[v].e_d_gnt));
            chk($sformatf("v%0d_mem_en", v),   32'(mem_en),   32'(vecs[v].e_i_gnt | vecs[v].e_d_gnt));
            chk($sformatf("v%0d_mem_we", v),   32'(mem_we),   32'(vecs[v].e_mem_we));
            chk($sformatf("v%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].e_mem_addr));
            chk($sformatf("v%0d_wdata", v),    mem_wdata,     vecs[v].e_mem_wdata);
            chk($sformatf("v%0d_i_rv", v),     32'(i_rvalid), 32'(vecs[v].e_i_rv));
            chk($sformatf("v%0d_d_rv", v),     32'(d_rvalid), 32'(vecs[v].e_d_rv));
            chk($sformatf("v%0d_i_rdata", v),  i_rdata,       vecs[v].e_i_rdata);
            chk($sformatf("v%0d_d_rdata", v),  d_rdata,       vecs[v].e_d_rdata);
            $display("vec %0d: i_gnt=%0b d_gnt=%0b mem_addr=%0d i_rv=%0b d_rv=%0b",
                     v, i_gnt, d_gnt, mem_addr, i_rvalid, d_rvalid);
            next_cycle();
        end

        // Contested cycle (d wins, fetch ages to 1), then 10 held cycles.
        drive(0, 1, 10'd3, 1, 0, 10'd4, 32'h0);
        chk("pre_hold_d_gnt", 32'(d_gnt), 32'h1);
        chk("pre_hold_cnt",   32'(dut.starve_cnt), 32'h0);
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            drive(1, 1, 10'd3, 1, 0, 10'd4, 32'h0);
            chk($sformatf("hold%0d_i_gnt", c),  32'(i_gnt),  32'h0);
            chk($sformatf("hold%0d_d_gnt", c),  32'(d_gnt),  32'h0);
            chk($sformatf("hold%0d_mem_en", c), 32'(mem_en), 32'h0);
            chk($sformatf("hold%0d_cnt", c),    32'(dut.starve_cnt), 32'h1);
            chk($sformatf("hold%0d_d_rv", c),   32'(d_rvalid), (c == 0) ? 32'h1 : 32'h0);
            chk($sformatf("hold%0d_d_rdata", c), d_rdata, 32'h1000_0004);
            $display("hold cycle %0d: mem_en=%0b starve=%0d", c, mem_en, dut.starve_cnt);
            next_cycle();
        end
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 10'd3, 1, 0, 10'd4, 32'h0);
            chk($sformatf("rel%0d_cnt", k),   32'(dut.starve_cnt), 32'(k));
            chk($sformatf("rel%0d_d_gnt", k), 32'(d_gnt), (k < 4) ? 32'h1 : 32'h0);
            chk($sformatf("rel%0d_i_gnt", k), 32'(i_gnt), (k == 4) ? 32'h1 : 32'h0);
            $display("release cycle %0d: i_gnt=%0b d_gnt=%0b", k, i_gnt, d_gnt);
            next_cycle();
        end

        // Four consecutive data wins from a fresh counter, then fetch wins.
        for (int k = 0; k <= 4; k++) begin
            drive(0, 1, 10'd1, 1, 0, 10'(100 + k), 32'h0);
            chk($sformatf("st%0d_cnt", k),   32'(dut.starve_cnt), 32'(k));
            chk($sformatf("st%0d_d_gnt", k), 32'(d_gnt), (k < 4) ? 32'h1 : 32'h0);
            chk($sformatf("st%0d_i_gnt", k), 32'(i_gnt), (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("st%0d_addr", k),  32'(mem_addr), (k < 4) ? 32'(100 + k) : 32'h1);
            $display("starve cycle %0d: i_gnt=%0b d_gnt=%0b addr=%0d", k, i_gnt, d_gnt, mem_addr);
            next_cycle();
        end
        drive(0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        chk("st_after_cnt",   32'(dut.starve_cnt), 32'h0);
        chk("st_after_i_rv",  32'(i_rvalid), 32'h1);
        chk("st_after_rdata", i_rdata, 32'h1000_0001);
        next_cycle();

        // Fetch grant followed immediately by hold: the read still returns.
        drive(0, 1, 10'd9, 0, 0, 10'd0, 32'h0);
        chk("fh_i_gnt", 32'(i_gnt), 32'h1);
        next_cycle();
        drive(1, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        chk("fh_i_rv",    32'(i_rvalid), 32'h1);
        chk("fh_i_rdata", i_rdata, 32'h1000_0009);
        chk("fh_mem_en",  32'(mem_en), 32'h0);
        $display("fetch+hold: i_rv=%0b i_rdata=%h", i_rvalid, i_rdata);
        next_cycle();
        drive(1, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        chk("fh_i_rv_once", 32'(i_rvalid), 32'h0);
        next_cycle();

        // Load grant, then reset asserted during the return cycle.
        drive(0, 0, 10'd0, 1, 0, 10'd12, 32'h0);
        chk("rm_d_gnt", 32'(d_gnt), 32'h1);
        next_cycle();
        drive(0, 1, 10'd2, 1, 0, 10'd12, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rm_d_rv",    32'(d_rvalid), 32'h0);
        chk("rm_d_rdata", d_rdata, 32'h0);
        chk("rm_i_rdata", i_rdata, 32'h0);
        chk("rm_mem_en",  32'(mem_en), 32'h0);
        chk("rm_i_gnt",   32'(i_gnt), 32'h0);
        chk("rm_d_gnt",   32'(d_gnt), 32'h0);
        $display("reset mid-read: d_rv=%0b mem_en=%0b", d_rvalid, mem_en);
        next_cycle();
        #1;
        chk("rm_d_rv_later", 32'(d_rvalid), 32'h0);
        drive(0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        rst_n = 1'b1;
        next_cycle();
        #1;
        chk("rm_after_d_rv", 32'(d_rvalid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares the single-port 1024x32 unified memory between the pipeline's instruction-fetch requester and its data requester (LW/SW). It grants at most one access per cycle and drives the memory port. It returns read data to the owning requester with fixed one-cycle latency. Data side has priority, and an aging counter bounds fetch starvation.

Parameters:
AW, 10, memory word-address width (1024 words)
DW, 32, data width
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins the next contested cycle

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  reset; asynchronous, active-low
hold  in  1  when 1, no new grants issue (pipeline halted)
i_req  in  1  fetch request, level; held until i_gnt
i_addr  in  AW  fetch word address
i_gnt  out  1  fetch granted this cycle
i_rvalid  out  1  i_rdata valid (cycle after i_gnt)
i_rdata  out  DW  fetched instruction
d_req  in  1  data request, level; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data word address
d_wdata  in  DW  store data
d_gnt  out  1  data granted this cycle
d_rvalid  out  1  d_rdata valid (cycle after a load grant)
d_rdata  out  DW  loaded word
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst_n=0, async): i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, starve_cnt=0, last_owner=NONE. Grant and memory outputs are 0 while in reset.
- Grant decision is combinational from the registered state:
  - Grants go low when hold=1 or when neither request is asserted.
  - If only one request is asserted, that requester is granted.
  - If both are asserted, d is granted unless starve_cnt >= STARVE_LIMIT, in which case i is granted.
- i_gnt and d_gnt are mutually exclusive. A grant drives mem_en=1 and mem_addr from the winner. mem_we=d_we is asserted only on a d grant. mem_wdata=d_wdata is driven on a d grant, otherwise 0.
- Handshake: a requester must hold req and its payload stable until it sees gnt in the same cycle. The transfer completes on the gnt edge. A requester may reassert req in the cycle after gnt, so back-to-back grants are allowed.
- Read return: owner register captures {I_RD, D_RD, NONE} at each grant. A store grant records NONE.
  - The next cycle, the matching rvalid pulses for one cycle and rdata registers mem_rdata.
  - rdata holds its value otherwise.
  - Latency is exactly 1 cycle from gnt to rvalid, independent of hold.
- Starvation counter (3 bits, saturating at 7):
  - Increments each cycle with i_req=1, hold=0 and no i_gnt.
  - Clears on i_gnt.
  - Holds while hold=1.
- Store-then-load at the same address: ordering follows grant order. A load granted the cycle after a store returns the new value.
- Simultaneous d store and i fetch to the same address: d wins; the fetch is served next and sees the stored data.
- hold asserted mid-operation: an already-issued read still returns its rvalid; no further grants issue until hold=0.
- Reset mid-read: the pending rvalid is dropped.
- Address wrap: none. Addresses are AW bits; no range checking.

State machine: owner register, states NONE/I_RD/D_RD, transitioning every cycle from the grant outcome as above.

Decomposition:
- Shared package mips_pkg holds:
  - AW/DW defaults
  - owner encoding (OWN_NONE=2'b00, OWN_I=2'b01, OWN_D=2'b10)
  - opcode/type constants already used by the pipeline (LW, SW, LOAD, STORE)
- One sub-module is natural: mips_starve_ctr, a saturating aging counter with inc/clr/hold and a >=limit compare.
- Arbitration and return logic stay in the top.

Test Plan:
- Reset then i_req=1, i_addr=5, d_req=0; memory[5]=0x2842_0001 -> i_gnt same cycle, mem_addr=5, i_rvalid next cycle with i_rdata=0x2842_0001, d_rvalid=0.
- Both requests held: d_req=1 (load, addr 100), i_req=1 -> d granted for 4 consecutive cycles (d keeps requesting new addresses), then i_gnt on cycle 5 with starve_cnt=4, then starve_cnt=0.
- d store addr 200 data 0xDEAD_BEEF, then d load addr 200 next cycle -> mem_we=1 on first grant, d_rvalid with 0xDEAD_BEEF one cycle after the second grant.
- hold=1 with both requests pending -> no gnt, mem_en=0, starve_cnt unchanged for 10 cycles. After hold drops, d granted first.
- Fetch grant then hold=1 next cycle -> i_rvalid still pulses once with correct data. Assert rst_n=0 in the cycle after a load grant -> d_rvalid stays 0 and all outputs are 0 immediately (asynchronously).
